// File: rtl/u_hzd_pkg.sv
// Shared types and constants for the hazard controller and its write scoreboard.
package u_hzd_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam int SB_W   = 2;
   localparam int NREG   = 32;
   localparam int ADDR_W = $clog2(NREG);

   localparam logic [SB_W-1:0] SB_MAX = SB_W'(3);

   typedef logic [SB_W-1:0]   sb_cnt_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/u_hzd_sb.sv
// Per-register in-flight write counters (x1..x31) with two source read ports,
// a destination-full check, drain hazard, pend_any and a sticky underflow flag.
module u_hzd_sb
   import u_hzd_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              inc_e,
   input  logic [ADDR_W-1:0] inc_a,
   input  logic              dec_e,
   input  logic [ADDR_W-1:0] dec_a,
   input  logic [ADDR_W-1:0] rd0_a,
   input  logic [ADDR_W-1:0] rd1_a,
   input  logic              drain,
   output logic [SB_W-1:0]   rd0_cnt,
   output logic [SB_W-1:0]   rd1_cnt,
   output logic              inc_full,
   output logic              drain_haz,
   output logic              pend_any,
   output logic              err
);

   sb_cnt_t         cnt [1:NREG-1];
   logic [NREG-1:1] inc_hit;
   logic [NREG-1:1] dec_hit;
   logic            dec_under;
   sb_cnt_t         inc_cnt;
   sb_cnt_t         dec_cnt;

   // x0 has no counter; any lookup of address 0 reads as idle.
   function automatic sb_cnt_t sb_read(input logic [ADDR_W-1:0] a);
      sb_cnt_t v;
      v = '0;
      for (int r = 1; r < NREG; r++) begin
         if (a == ADDR_W'(r)) v = cnt[r];
      end
      return v;
   endfunction

   always_comb begin
      // NOTE: every output of this block is assigned before any condition, so no latch is inferred.
      rd0_cnt   = sb_read(rd0_a);
      rd1_cnt   = sb_read(rd1_a);
      inc_cnt   = sb_read(inc_a);
      dec_cnt   = sb_read(dec_a);
      inc_full  = (inc_cnt == SB_MAX);
      dec_under = dec_e && (dec_a != '0) && (dec_cnt == '0);
      pend_any  = 1'b0;
      inc_hit   = '0;
      dec_hit   = '0;
      for (int r = 1; r < NREG; r++) begin
         if (cnt[r] != '0) pend_any = 1'b1;
         inc_hit[r] = inc_e && (inc_a == ADDR_W'(r)) && (cnt[r] != SB_MAX);
         dec_hit[r] = dec_e && (dec_a == ADDR_W'(r)) && (cnt[r] != '0);
      end
      drain_haz = drain && pend_any;
   end

   // NOTE: the counter array is reset explicitly; a stale pending count would stall decode forever.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 1; r < NREG; r++) cnt[r] <= '0;
         err <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every counter sees pre-edge values of its neighbours.
         for (int r = 1; r < NREG; r++) begin
            if (inc_hit[r] && !dec_hit[r])
               cnt[r] <= cnt[r] + SB_W'(1);
            else if (dec_hit[r] && !inc_hit[r])
               cnt[r] <= cnt[r] - SB_W'(1);
         end
         if (dec_under) err <= 1'b1;
      end
   end

endmodule

// File: rtl/u_hzd_ctrl.sv
// Decode hazard controller: RUN/FLUSH branch FSM, stall/issue decision and
// the write scoreboard that tracks results still in flight to the register file.
module u_hzd_ctrl
   import u_hzd_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1_a,
   input  logic [ADDR_W-1:0] id_rs2_a,
   input  logic              id_rs1_use,
   input  logic              id_rs2_use,
   input  logic [ADDR_W-1:0] id_rd_a,
   input  logic              id_rd_we,
   input  logic              id_drain,
   input  logic              branch,
   input  logic              rf_rd_e,
   input  logic [ADDR_W-1:0] rf_rd_a,
   output logic              stall,
   output logic              flush0,
   output logic              flush1,
   output logic              issue,
   output logic              pend_any,
   output logic              err
);

   state_t  state_q;
   state_t  state_d;
   logic    flush;
   logic    haz;
   logic    issue_i;
   sb_cnt_t rs1_cnt;
   sb_cnt_t rs2_cnt;
   logic    rd_full;
   logic    drain_haz;

   u_hzd_sb u_sb (
      .clk       (clk),
      .rstn      (rstn),
      .inc_e     (issue_i && id_rd_we),
      .inc_a     (id_rd_a),
      .dec_e     (rf_rd_e),
      .dec_a     (rf_rd_a),
      .rd0_a     (id_rs1_a),
      .rd1_a     (id_rs2_a),
      .drain     (id_drain),
      .rd0_cnt   (rs1_cnt),
      .rd1_cnt   (rs2_cnt),
      .inc_full  (rd_full),
      .drain_haz (drain_haz),
      .pend_any  (pend_any),
      .err       (err)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= RUN;
      else       state_q <= state_d;
   end

   // The branch cycle itself and the following FLUSH cycle both flush.
   always_comb begin
      state_d = state_q;
      flush   = 1'b0;
      unique case (state_q)
         RUN: begin
            if (branch) begin
               state_d = FLUSH;
               flush   = 1'b1;
            end
         end
         FLUSH: begin
            state_d = RUN;
            flush   = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      haz = (id_rs1_use && (rs1_cnt != '0)) ||
            (id_rs2_use && (rs2_cnt != '0)) ||
            (id_rd_we && rd_full) ||
            drain_haz;
   end

   // Combinational outputs are qualified with rstn so they read 0 throughout reset.
   assign issue_i = rstn && id_valid && !haz && !flush;
   assign issue   = issue_i;
   assign stall   = rstn && id_valid && haz && !flush;
   assign flush0  = rstn && flush;
   assign flush1  = rstn && flush;

endmodule

// File: tb/tb_u_hzd_ctrl.sv
// Directed scenarios followed by randomized traffic, checked against a
// per-register pending-count model of the hazard rules.
module tb_u_hzd_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       id_valid;
   logic [4:0] id_rs1_a;
   logic [4:0] id_rs2_a;
   logic       id_rs1_use;
   logic       id_rs2_use;
   logic [4:0] id_rd_a;
   logic       id_rd_we;
   logic       id_drain;
   logic       branch;
   logic       rf_rd_e;
   logic [4:0] rf_rd_a;
   logic       stall;
   logic       flush0;
   logic       flush1;
   logic       issue;
   logic       pend_any;
   logic       err;

   u_hzd_ctrl dut (
      .clk        (clk),
      .rstn       (rstn),
      .id_valid   (id_valid),
      .id_rs1_a   (id_rs1_a),
      .id_rs2_a   (id_rs2_a),
      .id_rs1_use (id_rs1_use),
      .id_rs2_use (id_rs2_use),
      .id_rd_a    (id_rd_a),
      .id_rd_we   (id_rd_we),
      .id_drain   (id_drain),
      .branch     (branch),
      .rf_rd_e    (rf_rd_e),
      .rf_rd_a    (rf_rd_a),
      .stall      (stall),
      .flush0     (flush0),
      .flush1     (flush1),
      .issue      (issue),
      .pend_any   (pend_any),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: outstanding writes per register, sticky error, flush-in-progress.
   int cnt_m [32];
   bit err_m;
   bit fl_m;

   logic last_stall, last_issue, last_flush0, last_flush1, last_pend, last_err;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   function automatic bit busy(input logic [4:0] a);
      return (a != 5'd0) && (cnt_m[a] != 0);
   endfunction

   function automatic bit model_pend();
      bit p = 1'b0;
      for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) p = 1'b1;
      return p;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      err_m = 1'b0;
      fl_m  = 1'b0;
   endtask

   task automatic set_id(input bit v, input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2,
                         input logic [4:0] rd, input bit we, input bit dr);
      id_valid = v;   id_rs1_a = rs1; id_rs1_use = u1;
      id_rs2_a = rs2; id_rs2_use = u2;
      id_rd_a  = rd;  id_rd_we = we;  id_drain = dr;
   endtask

   task automatic set_cm(input bit e, input logic [4:0] a);
      rf_rd_e = e;
      rf_rd_a = a;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      set_cm(1'b0, 5'd0);
      branch = 1'b0;
   endtask

   // Called 1 time unit after a rising edge: compare mid-cycle, then advance one clock.
   task automatic cyc(input string tag);
      bit e_fl, e_haz, e_st, e_is, e_pd;
      #1;
      e_pd  = model_pend();
      e_fl  = fl_m || branch;
      e_haz = (id_rs1_use && busy(id_rs1_a)) ||
              (id_rs2_use && busy(id_rs2_a)) ||
              (id_rd_we && id_rd_a != 5'd0 && cnt_m[id_rd_a] == 3) ||
              (id_drain && e_pd);
      e_st  = id_valid && e_haz && !e_fl;
      e_is  = id_valid && !e_haz && !e_fl;
      last_stall = stall;   last_issue = issue;
      last_flush0 = flush0; last_flush1 = flush1;
      last_pend = pend_any; last_err = err;
      chk($sformatf("%s.stall", tag),    stall,    e_st);
      chk($sformatf("%s.issue", tag),    issue,    e_is);
      chk($sformatf("%s.flush0", tag),   flush0,   e_fl);
      chk($sformatf("%s.flush1", tag),   flush1,   e_fl);
      chk($sformatf("%s.pend_any", tag), pend_any, e_pd);
      chk($sformatf("%s.err", tag),      err,      err_m);
      @(posedge clk);
      if (rf_rd_e && rf_rd_a != 5'd0) begin
         if (cnt_m[rf_rd_a] > 0) cnt_m[rf_rd_a]--;
         else err_m = 1'b1;
      end
      if (e_is && id_rd_we && id_rd_a != 5'd0 && cnt_m[id_rd_a] < 3) cnt_m[id_rd_a]++;
      fl_m = !fl_m && branch;
      #1;
   endtask

   // Asserts rstn asynchronously, checks outputs are forced low, releases after the next edge.
   task automatic do_reset(input string tag);
      rstn = 1'b0;
      #1;
      chk($sformatf("%s.stall", tag),    stall,    1'b0);
      chk($sformatf("%s.issue", tag),    issue,    1'b0);
      chk($sformatf("%s.flush0", tag),   flush0,   1'b0);
      chk($sformatf("%s.flush1", tag),   flush1,   1'b0);
      chk($sformatf("%s.pend_any", tag), pend_any, 1'b0);
      chk($sformatf("%s.err", tag),      err,      1'b0);
      model_clear();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      int n;
      int f;
      int r;
      idle();
      branch = 1'b1;
      id_valid = 1'b1;
      do_reset("rst0");
      idle();

      // Write x5, then a reader waits until x5 commits.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      cyc("s31_wr");
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);
      n = 0;
      repeat (3) begin cyc("s31_wait"); n += int'(last_stall); end
      set_cm(1'b1, 5'd5);
      cyc("s31_cm"); n += int'(last_stall);
      set_cm(1'b0, 5'd0);
      chk("s31_stall_cycles", n == 4, 1'b1);
      cyc("s31_go");
      chk("s31_issue_after_cm", last_issue, 1'b1);
      idle();

      // Branch while a hazard is present: two flush cycles, no stall, no issue.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      cyc("s32_wr");
      set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      branch = 1'b1;
      f = 0; n = 0;
      repeat (2) begin
         cyc("s32_fl");
         f += int'(last_flush0 && last_flush1);
         n += int'(last_stall || last_issue);
      end
      branch = 1'b0;
      cyc("s32_post");
      f += int'(last_flush0);
      chk("s32_flush_cycles", f == 2, 1'b1);
      chk("s32_no_stall_issue", n == 0, 1'b1);
      chk("s32_stall_resumes", last_stall, 1'b1);
      idle();
      set_cm(1'b1, 5'd6);
      cyc("s32_cm");
      idle();

      // Three writes to x7 saturate it; a fourth stalls until a commit frees one slot.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      repeat (3) cyc("s33_iss");
      set_cm(1'b1, 5'd7);
      cyc("s33_full");
      chk("s33_fourth_stalls", last_stall, 1'b1);
      set_cm(1'b0, 5'd0);
      cyc("s33_retry");
      chk("s33_fourth_issues", last_issue, 1'b1);
      idle();
      set_cm(1'b1, 5'd7);
      repeat (3) cyc("s33_drain");
      set_cm(1'b0, 5'd0);
      cyc("s33_empty");
      chk("s33_empty_pend", last_pend, 1'b0);

      // Same-cycle issue and commit on x9 leaves one write pending.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      cyc("s34_wr");
      set_cm(1'b1, 5'd9);
      cyc("s34_same");
      idle();
      cyc("s34_hold");
      chk("s34_pend_held", last_pend, 1'b1);
      set_cm(1'b1, 5'd9);
      cyc("s34_cm");
      set_cm(1'b0, 5'd0);
      cyc("s34_empty");
      chk("s34_one_commit_empties", last_pend, 1'b0);

      // Underflow on x3 sets sticky err; x0 is never tracked.
      set_cm(1'b1, 5'd3);
      cyc("s35_under");
      set_cm(1'b0, 5'd0);
      repeat (3) cyc("s35_sticky");
      chk("s35_err_sticky", last_err, 1'b1);
      chk("s35_no_pend", last_pend, 1'b0);
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc("s35_wr_x0");
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      cyc("s35_rd_x0");
      chk("s35_x0_no_stall", last_issue, 1'b1);
      chk("s35_x0_no_pend", last_pend, 1'b0);
      idle();

      // Drain waits for x4, then reset pulsed in the FLUSH cycle with x4 pending.
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
      cyc("s36_wr");
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      n = 0;
      repeat (2) begin cyc("s36_drain"); n += int'(last_stall); end
      set_cm(1'b1, 5'd4);
      cyc("s36_cm"); n += int'(last_stall);
      set_cm(1'b0, 5'd0);
      chk("s36_drain_stalls", n == 3, 1'b1);
      cyc("s36_drain_go");
      chk("s36_drain_issue", last_issue, 1'b1);
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
      cyc("s36_wr2");
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      branch = 1'b1;
      cyc("s36_br");
      do_reset("s36_rst");
      branch = 1'b0;
      cyc("s36_post");
      chk("s36_post_issue", last_issue, 1'b1);
      chk("s36_post_flush", last_flush0, 1'b0);
      chk("s36_post_pend", last_pend, 1'b0);
      chk("s36_post_err", last_err, 1'b0);
      idle();

      // Randomized traffic over x0..x7.
      for (int i = 0; i < 400; i++) begin
         set_id($urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                $urandom_range(0, 9) == 0);
         branch = $urandom_range(0, 11) == 0;
         r = $urandom_range(1, 7);
         if (cnt_m[r] > 0 && $urandom_range(0, 2) != 0) set_cm(1'b1, 5'(r));
         else set_cm(1'b0, 5'($urandom_range(0, 31)));
         cyc("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
